fcmp_jres: RTL and testbench
============================

FCMP_JRES -- requirements
Module: fcmp_jres

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the result queue depth in entries (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port in_vld, input, 1 bit: compare result valid from the FP compare unit.
REQ-005 SHALL have port in_rdy, output, 1 bit: the queue can accept an entry.
REQ-006 SHALL have port in_flags, input, 6 bits: {C,0,0,S,Z,U} compare flags.
REQ-007 SHALL have port in_jtype, input, 5 bits: condition selector.
REQ-008 SHALL have port in_tag, input, 9 bits: instruction tag.
REQ-009 SHALL have port in_pred, input, 1 bit: predicted-taken.
REQ-010 SHALL have port in_vec, input, 1 bit: entry is a packed vector compare, not a branch.
REQ-011 SHALL have port in_pkd, input, 68 bits: packed vector result {vtype[1:0], hi[32:0], lo[32:0]}.
REQ-012 SHALL have port flush, input, 1 bit: discard all queued entries.
REQ-013 SHALL have port out_vld, output, 1 bit: head entry valid.
REQ-014 SHALL have port out_rdy, input, 1 bit: consumer accepts the head entry.
REQ-015 SHALL have port out_tag, output, 9 bits: tag of the head entry.
REQ-016 SHALL have port out_taken, output, 1 bit: resolved branch direction.
REQ-017 SHALL have port out_mispred, output, 1 bit: out_taken differs from the queued in_pred.
REQ-018 SHALL have port out_vec, output, 1 bit: head entry is a vector entry.
REQ-019 SHALL have port out_mask, output, 2 bits: {hi[0], lo[0]} of the vector result.
REQ-020 SHALL have port out_vtype, output, 2 bits: vtype field of the vector result.
REQ-021 SHALL have port out_err, output, 1 bit: malformed entry.

Function
REQ-022 SHALL resolve the condition at enqueue from in_jtype, where C=in_flags[5], S=in_flags[2], Z=in_flags[1], U=in_flags[0].
- 0: Z
- 1: ~Z
- 2: C
- 3: ~C
- 4: C|Z
- 5: ~C&~Z
- 6: S
- 7: ~S
- 8: U
- 9: ~U
- 10: 1
- 11: 0
REQ-023 SHALL, for in_jtype 12..31 on a non-vector entry, force taken=0 and store err=1.
REQ-024 SHALL, for a vector entry, store taken=0 and mispred=0.
REQ-025 SHALL, for a vector entry, store err=1 when in_pkd[32:0] is not all-equal or in_pkd[65:33] is not all-equal.
REQ-026 SHALL store err=1 when in_flags[4:3] is nonzero on a non-vector entry.
REQ-027 SHALL push when in_vld && in_rdy.
REQ-028 SHALL pop when out_vld && out_rdy.
REQ-029 SHALL drive in_rdy = (count < DEPTH), independent of a same-cycle pop; there is no bypass when full.
REQ-030 SHALL present an entry on the outputs in the cycle after it is pushed into an empty queue (latency 1), with all outputs registered.
REQ-031 SHALL leave count unchanged on a simultaneous push and pop and keep FIFO order.
REQ-032 SHALL wrap the read and write pointers modulo DEPTH.
REQ-033 SHALL hold all out_* stable while out_vld && ~out_rdy.
REQ-034 SHALL, on flush, zero count and both pointers in the next cycle.
REQ-035 SHALL drop a push or pop presented in the same cycle as flush, with out_vld=0 the following cycle.
REQ-036 SHALL never let count exceed DEPTH or go below 0.
REQ-037 SHALL drive out_taken, out_mispred, out_mask, out_vtype and out_err to 0 whenever out_vld=0.

Reset
REQ-038 SHALL, while rst=0, asynchronously clear count, pointers, out_vld and all out_* to 0, and drive in_rdy=0.
REQ-039 SHALL raise in_rdy in the first clk edge after rst rises.
REQ-040 SHALL abandon queued entries on reset mid-operation without emitting them.

Verification
REQ-041 SHALL cover a branch entry: flags=6'b000010, jtype=0, pred=0, tag=9'h05 -> next cycle out_vld=1, out_taken=1, out_mispred=1, out_tag=9'h05.
REQ-042 SHALL cover a full queue: 4 pushes with out_rdy=0 -> in_rdy=0; a 5th in_vld is ignored; draining yields tags in push order, then out_vld=0.
REQ-043 SHALL cover a vector entry: in_vec=1, in_pkd={2'b01, 33'h1FFFFFFFF, 33'h0} -> out_vec=1, out_mask=2'b10, out_vtype=2'b01, out_err=0; flipping lo bit 5 -> out_err=1.
REQ-044 SHALL cover simultaneous push and pop at count=2 for 10 cycles -> count stays 2 with correct order across pointer wrap.
REQ-045 SHALL cover flush with push in the same cycle at count=3 -> out_vld=0 next cycle and in_rdy=1.
REQ-046 SHALL cover asynchronous rst low mid-burst between clk edges -> all outputs 0 immediately; jtype=13 after release -> out_err=1, out_taken=0.

Source files
------------

// File: rtl/fcmp_jres_if.sv
// Handshake bundle between the FP compare unit, the jump-resolve queue and its consumer.
// The master side produces compare results and consumes resolved entries; the slave is the queue.
interface fcmp_jres_if;
    logic        in_vld;
    logic        in_rdy;
    logic [5:0]  in_flags;
    logic [4:0]  in_jtype;
    logic [8:0]  in_tag;
    logic        in_pred;
    logic        in_vec;
    logic [67:0] in_pkd;
    logic        flush;
    logic        out_vld;
    logic        out_rdy;
    logic [8:0]  out_tag;
    logic        out_taken;
    logic        out_mispred;
    logic        out_vec;
    logic [1:0]  out_mask;
    logic [1:0]  out_vtype;
    logic        out_err;

    modport master (
        output in_vld, in_flags, in_jtype, in_tag, in_pred, in_vec, in_pkd, flush, out_rdy,
        input  in_rdy, out_vld, out_tag, out_taken, out_mispred, out_vec, out_mask, out_vtype, out_err
    );

    modport slave (
        input  in_vld, in_flags, in_jtype, in_tag, in_pred, in_vec, in_pkd, flush, out_rdy,
        output in_rdy, out_vld, out_tag, out_taken, out_mispred, out_vec, out_mask, out_vtype, out_err
    );
endinterface

// File: rtl/fcmp_jres.sv
// Jump-resolve queue: turns FP compare flags into branch outcomes (or vector masks) at enqueue
// and delivers them in order from a registered head with a DEPTH-entry FIFO behind it.
module fcmp_jres #(
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    fcmp_jres_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [8:0] tag;
        logic       taken;
        logic       mispred;
        logic       vec;
        logic [1:0] mask;
        logic [1:0] vtype;
        logic       err;
    } ent_t;

    // Codes 12..31 fall through to 0; the malformed flag is raised separately.
    function automatic logic cond_eval(input logic [4:0] jtype, input logic [5:0] flags);
        logic c, s, z, u;
        c = flags[5];
        s = flags[2];
        z = flags[1];
        u = flags[0];
        case (jtype)
            5'd0:    return z;
            5'd1:    return ~z;
            5'd2:    return c;
            5'd3:    return ~c;
            5'd4:    return c | z;
            5'd5:    return ~c & ~z;
            5'd6:    return s;
            5'd7:    return ~s;
            5'd8:    return u;
            5'd9:    return ~u;
            5'd10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ent_t resolve(input logic [5:0] flags, input logic [4:0] jtype,
                                     input logic [8:0] tag, input logic pred,
                                     input logic vec, input logic [67:0] pkd);
        ent_t        e;
        logic [32:0] lo;
        logic [32:0] hi;
        lo    = pkd[32:0];
        hi    = pkd[65:33];
        e     = '0;
        e.tag = tag;
        e.vec = vec;
        if (vec) begin
            // Each vector half must be a uniform lane mask (all zeros or all ones).
            e.mask  = {hi[0], lo[0]};
            e.vtype = pkd[67:66];
            e.err   = ~((&lo) | ~(|lo)) | ~((&hi) | ~(|hi));
        end else begin
            e.taken   = cond_eval(jtype, flags);
            e.mispred = e.taken ^ pred;
            e.err     = (jtype >= 5'd12) | (|flags[4:3]);
        end
        return e;
    endfunction

    ent_t          mem [DEPTH];
    ent_t          ent_p0;
    ent_t          head_p0;
    ent_t          ent_p1;
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          rdy_q;
    logic          vld_p1;
    logic          push;
    logic          pop;

    assign push = bus.in_vld & rdy_q & ~bus.flush;
    assign pop  = vld_p1 & bus.out_rdy & ~bus.flush;

    // Stage 0: resolve the incoming compare result
    always_comb ent_p0 = resolve(bus.in_flags, bus.in_jtype, bus.in_tag, bus.in_pred,
                                 bus.in_vec, bus.in_pkd);

    always_comb begin
        rd_nxt  = rd_ptr;
        wr_nxt  = wr_ptr;
        cnt_nxt = cnt;
        if (bus.flush) begin
            rd_nxt  = '0;
            wr_nxt  = '0;
            cnt_nxt = '0;
        end else begin
            if (push) wr_nxt = wr_ptr + AW'(1);
            if (pop)  rd_nxt = rd_ptr + AW'(1);
            cnt_nxt = cnt + CW'(push) - CW'(pop);
        end
    end

    // Next head: the entry being pushed when nothing else remains queued ahead of it.
    always_comb begin
        head_p0 = '0;
        if (cnt_nxt != '0)
            head_p0 = (push && (cnt == CW'(pop))) ? ent_p0 : mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ent_p0;
    end

    // Stage 1: registered queue state and head outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            rdy_q  <= 1'b0;
            vld_p1 <= 1'b0;
            ent_p1 <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            cnt    <= cnt_nxt;
            rdy_q  <= (cnt_nxt < FULL);
            vld_p1 <= (cnt_nxt != '0);
            ent_p1 <= head_p0;
        end
    end

    assign bus.in_rdy      = rdy_q;
    assign bus.out_vld     = vld_p1;
    assign bus.out_tag     = ent_p1.tag;
    assign bus.out_taken   = ent_p1.taken;
    assign bus.out_mispred = ent_p1.mispred;
    assign bus.out_vec     = ent_p1.vec;
    assign bus.out_mask    = ent_p1.mask;
    assign bus.out_vtype   = ent_p1.vtype;
    assign bus.out_err     = ent_p1.err;
endmodule

// File: tb/tb_fcmp_jres.sv
// Scoreboard bench for fcmp_jres: expected entries are queued at each accepted push and
// compared at each pop, plus directed checks around reset, full, flush and vector entries.
module tb_fcmp_jres;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nchk = 0;
    int   nerr = 0;
    int   npop = 0;
    logic armed;
    logic [16:0] sb_q[$];

    fcmp_jres_if bus ();

    fcmp_jres #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected entry {tag, taken, mispred, vec, mask[1:0], vtype[1:0], err}
    function automatic logic [16:0] model(input logic [5:0] f, input logic [4:0] j,
                                          input logic [8:0] t, input logic p,
                                          input logic v, input logic [67:0] k);
        logic [32:0] lo, hi;
        logic base, tk, er;
        lo = k[32:0];
        hi = k[65:33];
        if (v) begin
            er = !(lo == '0 || lo == '1) || !(hi == '0 || hi == '1);
            return {t, 3'b001, hi[0], lo[0], k[67:66], er};
        end
        case (j[4:1])
            4'd0:    base = f[1];
            4'd1:    base = f[5];
            4'd2:    base = f[5] | f[1];
            4'd3:    base = f[2];
            4'd4:    base = f[0];
            4'd5:    base = 1'b1;
            default: base = 1'b0;
        endcase
        tk = (j < 5'd12) ? (base ^ j[0]) : 1'b0;
        er = (j > 5'd11) || (f[4:3] != 2'b00);
        return {t, tk, tk ^ p, 1'b0, 4'b0000, er};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) armed <= 1'b0;
        else      armed <= 1'b1;
    end

    always @(negedge clk) begin
        logic [16:0] act;
        logic [16:0] e;
        if (!rst) begin
            sb_q.delete();
        end else begin
            chk("out_vld", 32'(bus.out_vld), 32'(sb_q.size() != 0));
            if (armed) chk("in_rdy", 32'(bus.in_rdy), 32'(sb_q.size() < DEPTH));
            if (!bus.out_vld)
                chk("idle_zero", 32'({bus.out_taken, bus.out_mispred, bus.out_mask,
                                      bus.out_vtype, bus.out_err}), 32'd0);
            if (bus.flush) begin
                sb_q.delete();
            end else begin
                if (bus.out_vld && bus.out_rdy && sb_q.size() != 0) begin
                    e   = sb_q.pop_front();
                    act = {bus.out_tag, bus.out_taken, bus.out_mispred, bus.out_vec,
                           bus.out_mask, bus.out_vtype, bus.out_err};
                    chk("entry", 32'(act), 32'(e));
                    npop++;
                end
                if (bus.in_vld && bus.in_rdy)
                    sb_q.push_back(model(bus.in_flags, bus.in_jtype, bus.in_tag, bus.in_pred,
                                         bus.in_vec, bus.in_pkd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [4:0] j, input logic [8:0] t,
                         input logic p, input logic v, input logic [67:0] k);
        bus.in_vld   = 1'b1;
        bus.in_flags = f;
        bus.in_jtype = j;
        bus.in_tag   = t;
        bus.in_pred  = p;
        bus.in_vec   = v;
        bus.in_pkd   = k;
    endtask

    function automatic logic [32:0] rnd_half();
        case ($urandom_range(2))
            0:       return 33'h0;
            1:       return {33{1'b1}};
            default: return {1'($urandom_range(1)), 32'($urandom)};
        endcase
    endfunction

    task automatic drive_rand(input logic [8:0] t);
        drive(6'($urandom), 5'($urandom_range(15)), t, 1'($urandom),
              ($urandom_range(3) == 0), {2'($urandom), rnd_half(), rnd_half()});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        logic [67:0] pk;
        bus.in_vld = 1'b0; bus.in_flags = '0; bus.in_jtype = '0; bus.in_tag = '0;
        bus.in_pred = 1'b0; bus.in_vec = 1'b0; bus.in_pkd = '0; bus.flush = 1'b0;
        bus.out_rdy = 1'b0;

        repeat (2) tick();
        chk("rst_in_rdy", 32'(bus.in_rdy), 32'd0);
        chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
        rst = 1'b1;
        #2;
        chk("rel_no_edge", 32'(bus.in_rdy), 32'd0);
        tick();
        chk("rel_in_rdy", 32'(bus.in_rdy), 32'd1);

        // Single branch entry, Z set, jtype 0, predicted not-taken
        drive(6'b000010, 5'd0, 9'h05, 1'b0, 1'b0, '0);
        tick();
        bus.in_vld = 1'b0;
        chk("br_vld", 32'(bus.out_vld), 32'd1);
        chk("br_taken", 32'(bus.out_taken), 32'd1);
        chk("br_mispred", 32'(bus.out_mispred), 32'd1);
        chk("br_tag", 32'(bus.out_tag), 32'h05);
        tick();
        chk("br_hold_tag", 32'(bus.out_tag), 32'h05);
        bus.out_rdy = 1'b1;
        tick();
        bus.out_rdy = 1'b0;
        chk("br_popped", 32'(bus.out_vld), 32'd0);

        // Fill to DEPTH, attempt an extra push, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            drive(6'b100000, 5'(i), 9'(9'h10 + i), 1'b1, 1'b0, '0);
            tick();
        end
        bus.in_vld = 1'b0;
        chk("full_rdy", 32'(bus.in_rdy), 32'd0);
        drive(6'b0, 5'd10, 9'h1F, 1'b0, 1'b0, '0);
        tick();
        bus.in_vld = 1'b0;
        bus.out_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("full_order", 32'(bus.out_tag), 32'(9'h10 + i));
            tick();
        end
        chk("full_drained", 32'(bus.out_vld), 32'd0);
        bus.out_rdy = 1'b0;

        // Vector entries: uniform halves, then a corrupted low half
        pk = {2'b01, {33{1'b1}}, 33'h0};
        drive(6'b0, 5'd0, 9'h20, 1'b0, 1'b1, pk);
        tick();
        bus.in_vld = 1'b0;
        chk("vec_flag", 32'(bus.out_vec), 32'd1);
        chk("vec_mask", 32'(bus.out_mask), 32'd2);
        chk("vec_vtype", 32'(bus.out_vtype), 32'd1);
        chk("vec_err", 32'(bus.out_err), 32'd0);
        chk("vec_taken", 32'(bus.out_taken), 32'd0);
        bus.out_rdy = 1'b1;
        tick();
        bus.out_rdy = 1'b0;
        pk[5] = 1'b1;
        drive(6'b0, 5'd0, 9'h21, 1'b1, 1'b1, pk);
        tick();
        bus.in_vld = 1'b0;
        chk("vec_bad_err", 32'(bus.out_err), 32'd1);
        chk("vec_bad_misp", 32'(bus.out_mispred), 32'd0);
        bus.out_rdy = 1'b1;
        tick();
        bus.out_rdy = 1'b0;

        // Steady push+pop at occupancy 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive_rand(9'(9'h40 + i));
            tick();
        end
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_rand(9'(9'h50 + i));
            tick();
            chk("pp_rdy", 32'(bus.in_rdy), 32'd1);
        end
        bus.in_vld = 1'b0;
        base = npop;
        repeat (4) tick();
        chk("pp_drain", 32'(npop - base), 32'd2);
        bus.out_rdy = 1'b0;

        // Flush together with a push at occupancy 3
        for (int i = 0; i < 3; i++) begin
            drive_rand(9'(9'h60 + i));
            tick();
        end
        drive_rand(9'h6F);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_vld = 1'b0;
        chk("fl_vld", 32'(bus.out_vld), 32'd0);
        chk("fl_rdy", 32'(bus.in_rdy), 32'd1);
        tick();
        chk("fl_dropped", 32'(bus.out_vld), 32'd0);

        // Random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(1)) drive_rand(9'($urandom));
            else bus.in_vld = 1'b0;
            bus.out_rdy = ($urandom_range(9) < 6);
            bus.flush   = ($urandom_range(49) == 0);
            tick();
        end
        bus.in_vld = 1'b0;
        bus.flush = 1'b0;
        bus.out_rdy = 1'b1;
        repeat (DEPTH + 2) tick();
        chk("rnd_drained", 32'(bus.out_vld), 32'd0);
        bus.out_rdy = 1'b0;

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            drive_rand(9'(9'h80 + i));
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        chk("arst_outs", 32'({bus.out_vld, bus.in_rdy, bus.out_tag, bus.out_taken,
                              bus.out_mispred, bus.out_vec, bus.out_mask, bus.out_vtype,
                              bus.out_err}), 32'd0);
        bus.in_vld = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("arst_rdy", 32'(bus.in_rdy), 32'd1);
        chk("arst_abandon", 32'(bus.out_vld), 32'd0);
        drive(6'b000000, 5'd13, 9'h99, 1'b1, 1'b0, '0);
        tick();
        bus.in_vld = 1'b0;
        chk("j13_err", 32'(bus.out_err), 32'd1);
        chk("j13_taken", 32'(bus.out_taken), 32'd0);
        bus.out_rdy = 1'b1;
        repeat (2) tick();
        chk("end_empty", 32'(bus.out_vld), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
